// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer width, Gray/binary conversion and the read-side flag bundle.
// Both pointer controllers import this package so their pointer encoding stays identical.
package fifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int PTR_W      = ADDR_WIDTH + 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [PTR_W-1:0] ptr_t;

  // Registered read-side status, kept together so a checker can bind to one signal.
  typedef struct packed {
    logic empty;
    logic almost_empty;
    ptr_t fill_level;
    logic rd_data_valid;
    logic underflow;
  } rd_flags_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port bundle of the dual-clock FIFO: consumer pop request, synchronized
// write pointer in, and address / Gray pointer / status flags out.
interface fifo_rd_ctrl_if;
  import fifo_pkg::*;

  // Handshake: rd_en is a request that may be held at any time; a pop is accepted on
  // every rising clk where rd_en && !empty, with empty acting as the only back-pressure.
  // rd_data_valid follows an accepted pop by exactly one cycle; rd_en while empty is
  // dropped and reported on underflow for one cycle.
  logic                  rd_en;
  ptr_t                  wr_ptr_gray_sync;
  logic [ADDR_WIDTH-1:0] rd_addr;
  ptr_t                  rd_ptr_gray;
  logic                  empty;
  logic                  almost_empty;
  ptr_t                  fill_level;
  logic                  rd_data_valid;
  logic                  underflow;

  modport master (
    output rd_en, wr_ptr_gray_sync,
    input  rd_addr, rd_ptr_gray, empty, almost_empty, fill_level, rd_data_valid, underflow
  );

  modport slave (
    input  rd_en, wr_ptr_gray_sync,
    output rd_addr, rd_ptr_gray, empty, almost_empty, fill_level, rd_data_valid, underflow
  );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer controller: owns the binary/Gray read pointer and derives the
// empty, almost-empty and fill flags from the already-synchronized write pointer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int AE_LEVEL = 2
) (
  input logic           clk,
  input logic           rst,
  fifo_rd_ctrl_if.slave bus
);

  ptr_t      rd_bin;
  ptr_t      rd_gray_q;
  rd_flags_t flags_q;

  logic      pop;
  ptr_t      rd_bin_next;
  ptr_t      rd_gray_next;
  ptr_t      wr_bin;
  ptr_t      diff;
  rd_flags_t flags_next;

  always_comb begin
    pop          = bus.rd_en && !flags_q.empty;
    rd_bin_next  = rd_bin + ptr_t'(pop);
    rd_gray_next = bin2gray(rd_bin_next);
    wr_bin       = gray2bin(bus.wr_ptr_gray_sync);
    diff         = wr_bin - rd_bin_next;

    flags_next               = '0;
    flags_next.empty         = (rd_gray_next == bus.wr_ptr_gray_sync);
    // A distance beyond DEPTH can only come from a corrupted pointer; clamp it.
    flags_next.fill_level    = (diff > ptr_t'(DEPTH)) ? ptr_t'(DEPTH) : diff;
    flags_next.almost_empty  = (flags_next.fill_level <= ptr_t'(AE_LEVEL));
    flags_next.rd_data_valid = pop;
    flags_next.underflow     = bus.rd_en && flags_q.empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin                <= '0;
      rd_gray_q             <= '0;
      flags_q.empty         <= 1'b1;
      flags_q.almost_empty  <= 1'b1;
      flags_q.fill_level    <= '0;
      flags_q.rd_data_valid <= 1'b0;
      flags_q.underflow     <= 1'b0;
    end else begin
      rd_bin    <= rd_bin_next;
      rd_gray_q <= rd_gray_next;
      flags_q   <= flags_next;
    end
  end

  assign bus.rd_addr       = rd_bin[ADDR_WIDTH-1:0];
  assign bus.rd_ptr_gray   = rd_gray_q;
  assign bus.empty         = flags_q.empty;
  assign bus.almost_empty  = flags_q.almost_empty;
  assign bus.fill_level    = flags_q.fill_level;
  assign bus.rd_data_valid = flags_q.rd_data_valid;
  assign bus.underflow     = flags_q.underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: vector table for pop/flag behaviour, hand-built lap/wrap and
// mid-burst reset sequences, and a queue that pairs each accepted pop with its valid.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  typedef struct {
    logic                  rd_en;
    ptr_t                  wg;
    logic [ADDR_WIDTH-1:0] e_addr;
    ptr_t                  e_gray;
    logic                  e_empty;
    logic                  e_ae;
    ptr_t                  e_fill;
    logic                  e_valid;
    logic                  e_uf;
  } vec_t;

  logic clk;
  logic rst;
  fifo_rd_ctrl_if bus ();

  fifo_rd_ctrl #(.AE_LEVEL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [ADDR_WIDTH-1:0] exp_q[$];
  logic                  prev_empty;
  logic [ADDR_WIDTH-1:0] prev_addr;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ptr_t g(input int n);
    ptr_t b;
    b = ptr_t'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic en, input ptr_t wg, input int addr, input int gray_bin,
                              input logic emp, input logic ae, input int fill, input logic vld,
                              input logic uf);
    vec_t v;
    v.rd_en = en; v.wg = wg; v.e_addr = ADDR_WIDTH'(addr); v.e_gray = g(gray_bin);
    v.e_empty = emp; v.e_ae = ae; v.e_fill = ptr_t'(fill); v.e_valid = vld; v.e_uf = uf;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  int'(bus.rd_addr), 0);
    chk({tag, "_gray"},  int'(bus.rd_ptr_gray), 0);
    chk({tag, "_empty"}, int'(bus.empty), 1);
    chk({tag, "_ae"},    int'(bus.almost_empty), 1);
    chk({tag, "_fill"},  int'(bus.fill_level), 0);
    chk({tag, "_valid"}, int'(bus.rd_data_valid), 0);
    chk({tag, "_uf"},    int'(bus.underflow), 0);
  endtask

  // driver + scoreboard: one clock edge per vector
  task automatic apply(input vec_t v, input string tag);
    logic [ADDR_WIDTH-1:0] pre_addr;
    bus.rd_en = v.rd_en;
    bus.wr_ptr_gray_sync = v.wg;
    if (v.rd_en && !prev_empty) exp_q.push_back(prev_addr);
    pre_addr = bus.rd_addr;
    @(posedge clk);
    #1;
    chk({tag, "_addr"},  int'(bus.rd_addr), int'(v.e_addr));
    chk({tag, "_gray"},  int'(bus.rd_ptr_gray), int'(v.e_gray));
    chk({tag, "_empty"}, int'(bus.empty), int'(v.e_empty));
    chk({tag, "_ae"},    int'(bus.almost_empty), int'(v.e_ae));
    chk({tag, "_fill"},  int'(bus.fill_level), int'(v.e_fill));
    chk({tag, "_valid"}, int'(bus.rd_data_valid), int'(v.e_valid));
    chk({tag, "_uf"},    int'(bus.underflow), int'(v.e_uf));
    if (bus.rd_data_valid) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_unexpected_valid"}, 1, 0);
      end else begin
        chk({tag, "_sb_addr"}, int'(pre_addr), int'(exp_q.pop_front()));
      end
    end
    prev_empty = v.e_empty;
    prev_addr  = v.e_addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_ptr_gray_sync = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    prev_empty = 1'b1;
    prev_addr  = '0;
  endtask

  initial begin
    int rb;
    int fill;
    rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_ptr_gray_sync = '0;
    prev_empty = 1'b1;
    prev_addr  = '0;

    // async reset before any clock edge
    #3;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;

    //            en  wg        addr gray emp ae fill vld uf
    tbl[0] = mk(0, 5'b00010, 0,   0,   0,  0, 3,   0,  0);
    tbl[1] = mk(1, 5'b00010, 1,   1,   0,  1, 2,   1,  0);
    tbl[2] = mk(1, 5'b00010, 2,   2,   0,  1, 1,   1,  0);
    tbl[3] = mk(1, 5'b00010, 3,   3,   1,  1, 0,   1,  0);
    tbl[4] = mk(1, 5'b00010, 3,   3,   1,  1, 0,   0,  1);
    tbl[5] = mk(0, 5'b00010, 3,   3,   1,  1, 0,   0,  0);
    tbl[6] = mk(0, g(5),     3,   3,   0,  1, 2,   0,  0);
    tbl[7] = mk(0, g(6),     3,   3,   0,  0, 3,   0,  0);
    tbl[8] = mk(1, g(7),     4,   4,   0,  0, 3,   1,  0);
    tbl[9] = mk(0, g(7),     4,   4,   0,  0, 3,   0,  0);
    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    chk("rd_ptr_gray_after_drain", int'(tbl[3].e_gray), 5'b00010);

    // threshold at rd_bin=0, illegal distance clamp, then a full lap and wrap
    do_reset();
    apply(mk(0, 5'b00011, 0, 0, 0, 1, 2, 0, 0), "thresh");
    apply(mk(0, g(20),    0, 0, 0, 0, 16, 0, 0), "clamp");
    apply(mk(0, 5'b11000, 0, 0, 0, 0, 16, 0, 0), "full");
    rb = 0;
    for (int k = 1; k <= 16; k++) begin
      fill = 16 - k;
      apply(mk(1, 5'b11000, k % 16, k, (fill == 0), (fill <= 2), fill, 1, 0),
            $sformatf("lap1_%0d", k));
      rb = k;
    end
    chk("lap1_gray_const", int'(bus.rd_ptr_gray), 5'b11000);
    apply(mk(0, 5'b10000, rb % 16, rb, 0, 0, 15, 0, 0), "lap2_fill");
    for (int k = rb + 1; k <= 31; k++) begin
      fill = 31 - k;
      apply(mk(1, 5'b10000, k % 16, k, (fill == 0), (fill <= 2), fill, 1, 0),
            $sformatf("lap2_%0d", k));
    end
    apply(mk(0, 5'b00000, 15, 31, 0, 1, 1, 0, 0), "wrap_fill");
    apply(mk(1, 5'b00000, 0, 0, 1, 1, 0, 1, 0), "wrap_pop");

    // reset asserted between edges during a pop burst
    apply(mk(0, g(8), 0, 0, 0, 0, 8, 0, 0), "burst_fill");
    apply(mk(1, g(8), 1, 1, 0, 0, 7, 1, 0), "burst1");
    apply(mk(1, g(8), 2, 2, 0, 0, 6, 1, 0), "burst2");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    bus.rd_en = 1'b0;
    bus.wr_ptr_gray_sync = '0;
    @(negedge clk);
    rst = 1'b0;
    prev_empty = 1'b1;
    prev_addr  = '0;
    apply(mk(1, 5'b00000, 0, 0, 1, 1, 0, 0, 1), "post_rst0");
    apply(mk(0, 5'b00000, 0, 0, 1, 1, 0, 0, 0), "post_rst1");
    apply(mk(0, g(1),     0, 0, 0, 1, 1, 0, 0), "post_rst_wr");
    apply(mk(1, g(1),     1, 1, 1, 1, 0, 1, 0), "post_rst_pop");

    chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side pointer controller for the dual-clock FIFO. It runs entirely in the read clock domain and owns the read pointer, the memory read address, and the empty/almost-empty/fill flags. It consumes the write pointer only after that pointer has passed through the 2-flop synchronizer in this domain. It publishes a Gray-coded read pointer for synchronization into the write domain.

## Interface
- ADDR_WIDTH, 4, memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- AE_LEVEL, 2, almost_empty asserts when fill_level <= AE_LEVEL
- Clocking: one clock, clk; reset is asynchronous and active-high, rst.
- clk  in  1  read-domain clock
- rst  in  1  asynchronous active-high reset
- rd_en  in  1  consumer pop request
- wr_ptr_gray_sync  in  ADDR_WIDTH+1  write pointer in Gray code, already 2-flop synchronized into clk
- rd_addr  out  ADDR_WIDTH  memory read address, equals rd_bin[ADDR_WIDTH-1:0]
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer
- empty  out  1  registered empty flag
- almost_empty  out  1  registered, fill_level <= AE_LEVEL
- fill_level  out  ADDR_WIDTH+1  registered, conservative occupancy 0..2**ADDR_WIDTH
- rd_data_valid  out  1  memory output valid, one cycle after an accepted pop
- underflow  out  1  one-cycle pulse on rd_en while empty

## Operation
- Accept: pop = rd_en && !empty. On pop, rd_bin increments modulo 2**(ADDR_WIDTH+1).
- Gray pointer: rd_ptr_gray <= bin2gray(rd_bin_next), registered in the same edge as rd_bin.
- Empty: empty <= (bin2gray(rd_bin_next) == wr_ptr_gray_sync).
- Fill: wr_bin = gray2bin(wr_ptr_gray_sync); fill_level <= (wr_bin - rd_bin_next) mod 2**(ADDR_WIDTH+1). The result clamps to 2**ADDR_WIDTH if it is larger (illegal input).
- almost_empty <= (fill_next <= AE_LEVEL).
- rd_data_valid <= pop. The memory samples rd_addr on the popping edge and presents data one cycle later.
- underflow <= rd_en && empty. The pointer does not move and rd_data_valid stays 0.
- Reset values: rd_bin 0, rd_ptr_gray 0, rd_addr 0, empty 1, almost_empty 1, fill_level 0, rd_data_valid 0, underflow 0.
- No FSM. State is the pointer register plus registered flags.

## Timing
- Pop to pointer update: 1 cycle. Pop to rd_data_valid: 1 cycle. Back-to-back pops are sustained at 1 per cycle.
- Popping the last entry asserts empty on the next edge, with no extra bubble. A pop can never be accepted past empty.
- A change on wr_ptr_gray_sync is reflected in empty/fill_level 1 cycle later. End-to-end write visibility is therefore ≥3 clk after the write-domain update, so the flags are pessimistic by design.
- A simultaneous pop and wr_ptr_gray_sync change use the next values of both, and the flags are consistent on the following edge.
- Wrap-around: rd_bin goes 2**(ADDR_WIDTH+1)-1 -> 0; rd_addr goes 2**ADDR_WIDTH-1 -> 0. The MSB distinguishes the lap. The Gray pointer changes exactly one bit per pop.
- Reset mid-operation: all outputs take reset values immediately, without waiting for a clock edge. An in-flight rd_data_valid is dropped. Reset release is synchronous to clk externally.

## Structure
- Package fifo_pkg holds:
  - ADDR_WIDTH default and localparam PTR_W = ADDR_WIDTH+1;
  - functions bin2gray and gray2bin (parameterized width via PTR_W), shared with the write-side controller.
- The block has no sub-module. The synchronizer for wr_ptr_gray_sync is instantiated by the FIFO top, not here.

## Test plan
All scenarios use ADDR_WIDTH=4 and AE_LEVEL=2.
- Reset: rst=1 asynchronously -> empty=1, almost_empty=1, fill_level=0, rd_ptr_gray=5'b00000, rd_data_valid=0, underflow=0.
- Fill 3 then drain: wr_ptr_gray_sync=5'b00010 (bin 3) -> next cycle empty=0, fill_level=3, almost_empty=0. Then 3 consecutive rd_en -> rd_addr 0,1,2; rd_data_valid high for 3 cycles, each one cycle after its pop. After the third pop: empty=1, fill_level=0, rd_ptr_gray=5'b00010.
- Underflow: rd_en=1 while empty -> underflow pulses 1 cycle, rd_addr unchanged, rd_data_valid=0.
- Threshold: wr_ptr_gray_sync=gray(2)=5'b00011 with rd_bin=0 -> empty=0, almost_empty=1, fill_level=2.
- Full lap and wrap: wr_ptr_gray_sync=5'b11000 (bin 16) -> fill_level=16. Pop 16 -> rd_addr wraps 15->0, rd_ptr_gray=5'b11000, empty=1. Repeat to rd_bin=31 (gray 5'b10000), next pop -> rd_ptr_gray=5'b00000.
- Reset mid-burst: assert rst between edges during continuous pops -> all outputs at reset values before the next clk edge. After release, empty=1 until wr_ptr_gray_sync changes.
